// File: rtl/prog_timer_if.sv
// Programmable timer bus.
//   master: drives start/stop/pause/mode/duration/prescale, observes status.
//   slave : the timer; drives count/busy/done/expired.
interface prog_timer_if #(
  parameter int WIDTH = 16,
  parameter int PW    = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] duration;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             expired;

  modport master (
    output start, stop, pause, mode, duration, prescale,
    input  count, busy, done, expired
  );

  modport slave (
    input  start, stop, pause, mode, duration, prescale,
    output count, busy, done, expired
  );
endinterface

// File: rtl/prog_timer.sv
// Programmable down-counting timer with prescaler, one-shot or periodic.
//   clk      : single clock, rising edge
//   rst      : synchronous, active-high reset
//   bus      : prog_timer_if.slave
//     start/stop/pause/mode/duration/prescale : control (duration, prescale
//                and mode are captured only on start)
//     count   : remaining ticks
//     busy    : high while running
//     done    : one-cycle pulse per expiry
//     expired : sticky expiry flag, cleared by start
module prog_timer #(
  parameter int WIDTH = 16,
  parameter int PW    = 8
) (
  input logic        clk,
  input logic        rst,
  prog_timer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic [PW-1:0]    pscale_q, pscale_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;
  logic             exp_q, exp_n;

  logic tick;
  logic zero_dur;
  logic last_tick;

  assign tick      = (presc_q == pscale_q);
  assign zero_dur  = (bus.duration == '0);
  assign last_tick = tick && (count_q == ONE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      pscale_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      presc_q  <= presc_n;
      pscale_q <= pscale_n;
      mode_q   <= mode_n;
      done_q   <= done_n;
      exp_q    <= exp_n;
    end
  end

  // Next state
  always_comb begin
    state_n = state_q;
    if (bus.start) begin
      // A zero duration expires immediately and never enters RUN.
      state_n = zero_dur ? IDLE : RUN;
    end else if (state_q == RUN) begin
      if (bus.stop)
        state_n = IDLE;
      else if (!bus.pause && last_tick && !mode_q)
        state_n = IDLE;
    end
  end

  // Next datapath values; start wins over stop, pause and any expiry tick.
  always_comb begin
    count_n  = count_q;
    reload_n = reload_q;
    presc_n  = presc_q;
    pscale_n = pscale_q;
    mode_n   = mode_q;
    exp_n    = exp_q;
    done_n   = 1'b0;
    if (bus.start) begin
      count_n  = bus.duration;
      reload_n = bus.duration;
      pscale_n = bus.prescale;
      mode_n   = bus.mode;
      presc_n  = '0;
      done_n   = zero_dur;
      exp_n    = zero_dur;
    end else if (state_q == RUN) begin
      if (bus.stop) begin
        count_n = '0;
        presc_n = '0;
      end else if (!bus.pause) begin
        if (tick) begin
          presc_n = '0;
          if (count_q == ONE) begin
            // Reload on the expiry tick itself so periodic mode has no gap.
            done_n  = 1'b1;
            exp_n   = 1'b1;
            count_n = mode_q ? reload_q : '0;
          end else if (count_q != '0) begin
            count_n = count_q - ONE;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
    end
  end

  // Outputs straight from registers
  always_comb begin
    bus.count   = count_q;
    bus.busy    = (state_q == RUN);
    bus.done    = done_q;
    bus.expired = exp_q;
  end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 16: width of duration and count.
REQ-002 Parameter PW, default 8: width of prescale.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  load duration/prescale/mode and run; restarts if already running.
REQ-006 stop  input  1  abort the running timer without done.
REQ-007 pause  input  1  level; freeze prescaler and count while high.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled on start.
REQ-009 duration  input  WIDTH  tick count to expiry; sampled on start.
REQ-010 prescale  input  PW  one tick every prescale+1 clk cycles; sampled on start.
REQ-011 count  output  WIDTH  current remaining ticks.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse per expiry.
REQ-014 expired  output  1  sticky; set with every done, cleared by start.

Function
REQ-015 State machine SHALL have two states, IDLE and RUN; registered outputs only.
REQ-016 Priority per edge SHALL be rst > start > stop > pause > tick.
REQ-017 start SHALL latch duration into count and reload register, prescale and mode into shadow registers, clear the prescaler, clear expired, and enter RUN, from either state.
REQ-018 start with duration == 0 SHALL pulse done on the next cycle, set expired, leave count = 0 and return to IDLE, in either mode.
REQ-019 In RUN without pause, the prescaler SHALL increment each cycle and generate a tick and return to 0 when it equals the latched prescale.
REQ-020 On a tick with count > 1, count SHALL decrement by 1.
REQ-021 On a tick with count == 1, done SHALL be 1 for the following cycle and expired SHALL set; one-shot: count <= 0, go IDLE; periodic: count <= reload value, stay RUN.
REQ-022 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k + D*(P+1) (D = duration, P = prescale), with no pause.
REQ-023 Periodic mode SHALL produce done every D*(P+1) cycles, with no cycle gap or slip at reload.
REQ-024 pause SHALL hold count, prescaler and state unchanged; busy remains 1; pause in IDLE SHALL have no effect.
REQ-025 stop in RUN SHALL set count <= 0, clear the prescaler, go IDLE, and assert no done; stop in IDLE SHALL have no effect.
REQ-026 start and stop together SHALL execute start; start coincident with an expiry tick SHALL execute start and suppress that done.
REQ-027 Changes to duration/prescale/mode while running SHALL have no effect until the next start.
REQ-028 Arithmetic SHALL be unsigned; count never wraps below 0; prescale = 2^PW-1 and duration = 2^WIDTH-1 SHALL work without overflow.
REQ-029 done SHALL never be high for two consecutive cycles except in periodic mode with D*(P+1) == 1.

Reset
REQ-030 rst high at an edge SHALL set state IDLE, count = 0, prescaler = 0, busy = 0, done = 0, expired = 0, and clear the shadow registers, overriding all other inputs.
REQ-031 rst mid-run SHALL abort with no done pulse; the first start after rst release SHALL behave as from power-up.

Verification
REQ-032 One-shot, D=5, P=0, start at cycle 0 -> count 5,4,3,2,1,0; done high in cycle 5 only; busy falls with done; expired stays 1.
REQ-033 Periodic, D=3, P=2 -> done every 9 cycles for at least 4 periods; count reloads to 3; busy stays 1.
REQ-034 One-shot, D=4, P=0, pause high for 3 cycles after the second tick -> done delayed by exactly 3 cycles (cycle 7).
REQ-035 Running periodic, stop, then start+stop in the same cycle -> first: IDLE, count 0, no done; second: restarts with the new duration.
REQ-036 start with D=0 -> done one cycle later, IDLE; rst asserted mid-run with D=10 -> all outputs 0 next cycle, no done.
REQ-037 WIDTH=8, PW=4, D=255, P=15 -> done at cycle 4080 exactly; no wrap of count or prescaler.
